fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch stage with a decoupling buffer between instruction memory and decode. It owns the fetch PC, issues one sequential request per cycle to a synchronous instruction memory, and captures returning words with their PC and sequential-next PC into a DEPTH-entry FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect (branch, jump or trap) flushes the FIFO and restarts fetch at a new PC.

## Interface
- XLEN, 32: width of PC, instruction and snPC.
- DEPTH, 4: FIFO entries. Power of two, at least 2. Full throughput needs at least 3.
- RESET_PC, 32'h0000_0000: fetch PC loaded while in reset.

- clk  in  1  clock. All state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch PC.
- stall  in  1  inhibits new memory requests. Does not affect the FIFO.
- imem_req  out  1  request strobe.
- imem_addr  out  XLEN  request address, equal to the fetch PC.
- imem_rdata  in  XLEN  read data, valid exactly one cycle after the imem_req cycle.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_pc, out_snpc, out_instr  out  XLEN each  head entry fields.
- occupancy  out  $clog2(DEPTH)+1  current FIFO count.

## Operation
- State:
  - fetch PC `pc`.
  - FIFO storage with read and write pointers (wrap modulo DEPTH) and a count.
  - `inflight` (1 bit) and `inflight_pc`, meaning a response is due this cycle.
- `imem_req = rst_n & ~redirect_valid & ~stall & (count + inflight < DEPTH)`. This is combinational and ignores a same-cycle dequeue. `imem_addr = pc`.
- On an issue cycle:
  - `pc <= pc + 4`, modulo 2^XLEN. Wrap from all-ones-minus-3 to 0 is silent.
  - `inflight <= 1`, `inflight_pc <= pc`.
  - Otherwise `inflight <= 0`.
- On a response cycle (`inflight == 1`), push {inflight_pc, inflight_pc + 4, imem_rdata}. The issue rule guarantees the FIFO is never full at push time.
- Pop happens when `out_valid & out_ready`. A push and a pop in the same cycle leave count unchanged. Both pointers advance.
- Redirect has priority over every other event:
  - `pc <= redirect_pc`; count, pointers and inflight are cleared.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle still counts as accepted by decode.
  - No request is issued in the redirect cycle.
- Stall only gates issue. In-flight responses still land, and the FIFO still drains.
- Reset (rst_n low at posedge): `pc = RESET_PC`, count 0, pointers 0, inflight 0. During reset, imem_req is 0, out_valid is 0 and occupancy is 0. Reset mid-stream discards all queued and in-flight data.

## Timing
- Request in cycle N, response in N+1, entry visible at the FIFO head in N+2 (without bypass).
- Redirect asserted in cycle R gives the first request to redirect_pc in R+1 and the first out_valid in R+3 (R+2 with bypass).
- `out_valid = (count != 0)`. The head fields stay stable while out_valid is high and out_ready is low.
- Steady state with out_ready held high and DEPTH at least 3: one instruction per cycle.

## Configuration
- FETCHQ_BYPASS_EN defined:
  - When count is 0 and a response arrives, the response is presented on out_* in the same cycle with out_valid high.
  - If out_ready is high, the response is consumed without being pushed. Otherwise it is pushed as normal.
  - This saves one cycle of fetch-to-decode latency.
  - Combinational path: imem_rdata to out_instr.
- Undefined: outputs come only from FIFO registers, and there is no combinational path from imem to out_*.

## Test plan
- Reset, then release with out_ready=1 and RESET_PC=0 → out_pc sequence 0, 4, 8, … with out_snpc = out_pc+4 and out_instr = memory word. One per cycle after the fill latency.
- Hold out_ready=0 → occupancy saturates at DEPTH=4, imem_req drops to 0, and no entry is lost or duplicated after out_ready returns to 1.
- Assert redirect_valid with redirect_pc=32'h100 while the FIFO holds 3 entries and a response is in flight → occupancy 0 next cycle, the stale response is dropped, and the next out_pc is 32'h100.
- Assert stall for 5 cycles mid-stream → no imem_req during the stall, the FIFO drains normally, and fetch resumes at the next sequential PC with no gap or repeat.
- Drop rst_n for one cycle mid-stream → out_valid=0, occupancy=0, imem_addr=RESET_PC after release.
- Set pc near 32'hFFFF_FFF8 via redirect → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, with out_snpc wrapping to 0 and then 4.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode-facing valid/ready head.
// The fetch queue drives the master side; memory and decode together sit on the slave side.
interface fetch_queue_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_snpc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_snpc,
    output out_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_snpc,
    input  out_instr
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues sequential requests and buffers responses in a DEPTH-entry FIFO.
// Optional FETCHQ_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall,
  fetch_queue_if.master          bus,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  cnt_t            count_q, count_d;

  logic [XLEN-1:0] ent_pc_q    [DEPTH];
  logic [XLEN-1:0] ent_snpc_q  [DEPTH];
  logic [XLEN-1:0] ent_instr_q [DEPTH];

  logic [CNT_W:0]  pending;
  logic            issue;
  logic            fifo_valid;
  logic            pop;
  logic            push;
  logic            bypass_take;

  // Outstanding work counts the in-flight response so a push can never hit a full FIFO.
  assign pending = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue   = rst_n & ~redirect_valid & ~stall & (pending < DEPTH_LIM);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;

  assign fifo_valid = rst_n & (count_q != '0);
  assign pop        = fifo_valid & bus.out_ready;
  assign occupancy  = rst_n ? count_q : '0;

`ifdef FETCHQ_BYPASS_EN
  logic bypass_hit;

  // A response discarded by a redirect must never reach decode, so redirect also blocks the bypass.
  assign bypass_hit  = rst_n & inflight_q & (count_q == '0) & ~redirect_valid;
  assign bypass_take = bypass_hit & bus.out_ready;

  always_comb begin
    bus.out_valid = fifo_valid;
    bus.out_pc    = ent_pc_q[rd_ptr_q];
    bus.out_snpc  = ent_snpc_q[rd_ptr_q];
    bus.out_instr = ent_instr_q[rd_ptr_q];
    if (bypass_hit) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = inflight_pc_q;
      bus.out_snpc  = inflight_pc_q + XLEN'(4);
      bus.out_instr = bus.imem_rdata;
    end
  end
`else
  assign bypass_take = 1'b0;

  always_comb begin
    bus.out_valid = fifo_valid;
    bus.out_pc    = ent_pc_q[rd_ptr_q];
    bus.out_snpc  = ent_snpc_q[rd_ptr_q];
    bus.out_instr = ent_instr_q[rd_ptr_q];
  end
`endif

  assign push = rst_n & inflight_q & ~redirect_valid & ~bypass_take;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + XLEN'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Entry storage needs no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[wr_ptr_q]    <= inflight_pc_q;
      ent_snpc_q[wr_ptr_q]  <= inflight_pc_q + XLEN'(4);
      ent_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a memory model answers requests and a scoreboard of expected PCs
// checks every entry decode accepts, along with reset, backpressure, redirect, stall and wrap behaviour.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCHQ_BYPASS_EN
  localparam int FILL_LAT = 1;
`else
  localparam int FILL_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [2:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic        last_req;

  fetch_queue_if #(.XLEN(XLEN)) bus ();

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .bus            (bus),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Synchronous instruction memory: data for a request appears the cycle after it.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
    else              bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check what the DUT presents for this cycle.
  task automatic applyStimulus(input logic rst_v, input logic ready_v, input logic stall_v,
                               input logic redir_v, input logic [31:0] rpc);
    logic [31:0] exp_pc;
    @(negedge clk);
    rst_n          = rst_v;
    bus.out_ready  = ready_v;
    stall          = stall_v;
    redirect_valid = redir_v;
    redirect_pc    = rpc;
    #1;
    if (!rst_v) begin
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_occupancy", occupancy, 0);
      checkOutput("rst_imem_req", bus.imem_req, 0);
    end
    if (stall_v || redir_v) checkOutput("req_gated", bus.imem_req, 0);
    checkOutput("occ_bound", occupancy <= 3'(DEPTH), 1);
    if (bus.out_valid && ready_v) begin
      while (exp_q.size() < DEPTH) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      exp_pc = exp_q.pop_front();
      checkOutput("out_pc", bus.out_pc, exp_pc);
      checkOutput("out_snpc", bus.out_snpc, exp_pc + 32'd4);
      checkOutput("out_instr", bus.out_instr, mem_word(exp_pc));
      pops++;
    end
    if (!rst_v) begin
      exp_q.delete();
      next_pc = RESET_PC;
    end else if (redir_v) begin
      exp_q.delete();
      next_pc = rpc;
    end
    last_req = bus.imem_req;
  endtask

  initial begin
    logic        found;
    logic        req_before;
    logic        r_ready, r_stall, r_redir;
    logic [31:0] r_pc;

    rst_n          = 1'b0;
    bus.out_ready  = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    next_pc        = RESET_PC;
    last_req       = 1'b0;

    repeat (3) applyStimulus(0, 1, 0, 0, 32'h0);

    // Release from reset: sequential stream with the expected fill latency.
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 1, 0, 0, 32'h0);
      if (c == 0) begin
        checkOutput("reset_addr", bus.imem_addr, RESET_PC);
        checkOutput("first_req", bus.imem_req, 1);
      end
      if (c < FILL_LAT) checkOutput("fill_valid_low", bus.out_valid, 0);
      else if (c == FILL_LAT) checkOutput("fill_valid_high", bus.out_valid, 1);
    end
    pops = 0;
    repeat (10) applyStimulus(1, 1, 0, 0, 32'h0);
    checkOutput("throughput", pops, 10);

    // Backpressure: FIFO saturates and fetch stops, then drains without loss.
    repeat (10) applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("full_occupancy", occupancy, DEPTH);
    checkOutput("full_imem_req", bus.imem_req, 0);
    repeat (12) applyStimulus(1, 1, 0, 0, 32'h0);

    // Redirect while three entries are queued and one response is in flight.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      applyStimulus(1, 0, 0, 0, 32'h0);
      if (occupancy == 3'd2) found = 1'b1;
    end
    checkOutput("reach_occ_two", found, 1);
    req_before = last_req;
    applyStimulus(1, 0, 0, 1, 32'h0000_0100);
    checkOutput("pre_redir_occ", occupancy, 3);
    checkOutput("pre_redir_inflight", req_before, 1);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("post_redir_occ", occupancy, 0);
    checkOutput("post_redir_valid", bus.out_valid, 0);
    checkOutput("post_redir_req", bus.imem_req, 1);
    checkOutput("post_redir_addr", bus.imem_addr, 32'h0000_0100);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("redir_r2_valid", bus.out_valid, (FILL_LAT == 1) ? 1 : 0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("redir_r3_valid", bus.out_valid, 1);
    checkOutput("redir_r3_pc", bus.out_pc, 32'h0000_0100);
    repeat (12) applyStimulus(1, 1, 0, 0, 32'h0);

    // Stall mid-stream: no requests, FIFO drains, fetch resumes in sequence.
    repeat (5) applyStimulus(1, 1, 1, 0, 32'h0);
    checkOutput("stall_drained", occupancy, 0);
    repeat (10) applyStimulus(1, 1, 0, 0, 32'h0);

    // One-cycle reset mid-stream.
    applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkOutput("rerst_valid", bus.out_valid, 0);
    checkOutput("rerst_occ", occupancy, 0);
    checkOutput("rerst_addr", bus.imem_addr, RESET_PC);
    repeat (10) applyStimulus(1, 1, 0, 0, 32'h0);

    // PC wrap through the top of the address space.
    applyStimulus(1, 1, 0, 1, 32'hFFFF_FFF8);
    pops = 0;
    repeat (10) applyStimulus(1, 1, 0, 0, 32'h0);
    checkOutput("wrap_pops", pops, 10 - FILL_LAT);

    // Random mix of backpressure, stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      r_ready = ($urandom_range(0, 3) != 0);
      r_stall = ($urandom_range(0, 7) == 0);
      r_redir = ($urandom_range(0, 39) == 0);
      r_pc    = $urandom & 32'hFFFF_FFFC;
      applyStimulus(1, r_ready, r_stall, r_redir, r_pc);
    end
    repeat (10) applyStimulus(1, 1, 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
